deadtime_gate_driver: RTL

Consumes the switching variable sigma from the hybrid controller and produces the two complementary half-bridge gate commands for the resonant converter.
- Inserts a fixed dead-time, with both gates off, on every commutation.
- Enforces a minimum on-time per leg, which suppresses chattering of sigma near the jump surface.
- Measures the resulting switching period for monitoring on the debug path.

---
 rtl/deadtime_gate_driver.sv | 139 +++++++++++++
 1 files changed

// File: rtl/deadtime_gate_driver.sv
// Half-bridge gate driver: turns the controller's switching variable into two
// complementary gate commands with fixed dead-time, minimum on-time and period monitor.
module deadtime_gate_driver #(
   parameter int unsigned DEADTIME = 20,
   parameter int unsigned MIN_ON   = 100,
   parameter int unsigned CNT_W    = 16
) (
   input  logic             i_clock,
   input  logic             i_RESET,
   input  logic             i_sigma,
   input  logic             i_enable,
   output logic             o_gate_H,
   output logic             o_gate_L,
   output logic [2:0]       o_state,
   output logic [CNT_W-1:0] o_period,
   output logic             o_period_valid
);

   typedef enum logic [2:0] {
      ST_OFF     = 3'd0,
      ST_DT_TO_H = 3'd1,
      ST_HIGH    = 3'd2,
      ST_DT_TO_L = 3'd3,
      ST_LOW_ON  = 3'd4
   } state_e;

   localparam logic [CNT_W-1:0] DT_LAST  = CNT_W'(DEADTIME);
   localparam logic [CNT_W-1:0] MIN_ON_C = CNT_W'(MIN_ON);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   state_e           state_q;
   logic             sigma_q;
   logic             first_edge_q;
   logic [CNT_W-1:0] dt_cnt_q;
   logic [CNT_W-1:0] dwell_cnt_q;
   logic [CNT_W-1:0] per_cnt_q;
   logic             gate_h_q;
   logic             gate_l_q;
   logic [CNT_W-1:0] period_q;
   logic             period_valid_q;

   logic [CNT_W-1:0] dwell_d;
   logic [CNT_W-1:0] per_d;
   logic             dwell_met_c;

   // Saturating counter increments; dwell is judged on its incremented value so a
   // leg stays on for exactly MIN_ON cycles at minimum.
   always_comb begin
      dwell_d     = (dwell_cnt_q >= MIN_ON_C) ? dwell_cnt_q : dwell_cnt_q + CNT_ONE;
      per_d       = (per_cnt_q == CNT_MAX) ? per_cnt_q : per_cnt_q + CNT_ONE;
      dwell_met_c = (dwell_d >= MIN_ON_C);
   end

   always_ff @(posedge i_clock) begin
      if (i_RESET) begin
         state_q        <= ST_OFF;
         sigma_q        <= 1'b0;
         first_edge_q   <= 1'b1;
         dt_cnt_q       <= '0;
         dwell_cnt_q    <= '0;
         per_cnt_q      <= '0;
         gate_h_q       <= 1'b0;
         gate_l_q       <= 1'b0;
         period_q       <= '0;
         period_valid_q <= 1'b0;
      end else begin
         sigma_q        <= i_sigma;
         per_cnt_q      <= per_d;
         period_valid_q <= 1'b0;
         if (!i_enable) begin
            state_q  <= ST_OFF;
            gate_h_q <= 1'b0;
            gate_l_q <= 1'b0;
         end else begin
            unique case (state_q)
               ST_OFF: begin
                  first_edge_q <= 1'b1;
                  dt_cnt_q     <= CNT_ONE;
                  state_q      <= sigma_q ? ST_DT_TO_H : ST_DT_TO_L;
               end
               ST_DT_TO_H: begin
                  if (dt_cnt_q >= DT_LAST) begin
                     state_q      <= ST_HIGH;
                     gate_h_q     <= 1'b1;
                     dwell_cnt_q  <= '0;
                     per_cnt_q    <= CNT_ONE;
                     first_edge_q <= 1'b0;
                     // First rising edge after enable has no predecessor to measure from
                     if (!first_edge_q) begin
                        period_q       <= per_cnt_q;
                        period_valid_q <= 1'b1;
                     end
                  end else begin
                     dt_cnt_q <= dt_cnt_q + CNT_ONE;
                  end
               end
               ST_HIGH: begin
                  dwell_cnt_q <= dwell_d;
                  if (!sigma_q && dwell_met_c) begin
                     state_q  <= ST_DT_TO_L;
                     gate_h_q <= 1'b0;
                     dt_cnt_q <= CNT_ONE;
                  end
               end
               ST_DT_TO_L: begin
                  if (dt_cnt_q >= DT_LAST) begin
                     state_q     <= ST_LOW_ON;
                     gate_l_q    <= 1'b1;
                     dwell_cnt_q <= '0;
                  end else begin
                     dt_cnt_q <= dt_cnt_q + CNT_ONE;
                  end
               end
               ST_LOW_ON: begin
                  dwell_cnt_q <= dwell_d;
                  if (sigma_q && dwell_met_c) begin
                     state_q  <= ST_DT_TO_H;
                     gate_l_q <= 1'b0;
                     dt_cnt_q <= CNT_ONE;
                  end
               end
               default: begin
                  state_q  <= ST_OFF;
                  gate_h_q <= 1'b0;
                  gate_l_q <= 1'b0;
               end
            endcase
         end
      end
   end

   assign o_gate_H       = gate_h_q;
   assign o_gate_L       = gate_l_q;
   assign o_state        = state_q;
   assign o_period       = period_q;
   assign o_period_valid = period_valid_q;

endmodule
